// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, S-box, GF(2^8) helpers and sequencer state type
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int NR_128    = 10;
    localparam int NR_192    = 12;
    localparam int NR_256    = 14;

    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul_3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

endpackage

// File: rtl/aes_round_seq_if.sv
// aes_round_seq_if: host-side plaintext in / ciphertext out valid-ready channels
interface aes_round_seq_if;
    import aes_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [AES_BLK_W-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [AES_BLK_W-1:0] out_data;

    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);

endinterface

// File: rtl/aes_round_fn.sv
// aes_round_fn: one combinational AES round; MixColumns bypassed on the final round
module aes_round_fn
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] st,
    input  logic [AES_BLK_W-1:0] rk,
    input  logic                 last,
    output logic [AES_BLK_W-1:0] nxt
);

    logic [AES_BLK_W-1:0] sr;
    logic [AES_BLK_W-1:0] mc;

    // SubBytes fused with ShiftRows: row r takes its byte from column (c+r) mod 4
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[127-32*c-8*r -: 8] = sbox(st[127-32*((c+r)%4)-8*r -: 8]);
        end
    end

    mixcolumn u_mc (
        .din  (sr),
        .dout (mc)
    );

    assign nxt = (last ? sr : mc) ^ rk;

endmodule

// File: rtl/mixcolumn.sv
// mixcolumn: AES MixColumns over all four columns of a 128-bit state
module mixcolumn
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] din,
    output logic [AES_BLK_W-1:0] dout
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign {a0, a1, a2, a3} = din[127-32*c -: 32];
        assign dout[127-32*c -: 32] = {
            xtime(a0) ^ mul_3(a1) ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ mul_3(a2) ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ mul_3(a3),
            mul_3(a0) ^ a1 ^ a2 ^ xtime(a3)
        };
    end

endmodule

// File: rtl/aes_round_seq.sv
// aes_round_seq: iterative AES encryption, one round per clock; AES_ROUND_SEQ_ABORT_EN adds an abort input
module aes_round_seq
    import aes_pkg::*;
#(
    parameter int NR    = 10,
    parameter int RKI_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_round_seq_if.slave       bus,
    output logic [RKI_W-1:0]     rk_idx,
    input  logic [AES_BLK_W-1:0] rk_data,
`ifdef AES_ROUND_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 busy
);

    if ((NR != NR_128 && NR != NR_192 && NR != NR_256) || NR >= (1 << RKI_W)) begin : g_bad_nr
        $error("aes_round_seq: NR must be 10, 12 or 14 and fit in RKI_W bits");
    end

    seq_state_t           state;
    logic [RKI_W-1:0]     rnd;
    logic [AES_BLK_W-1:0] st;
    logic [AES_BLK_W-1:0] nxt;
    logic                 last;

    assign last         = rnd == RKI_W'(NR);
    assign rk_idx       = rnd;
    assign bus.out_data = st;

    aes_round_fn u_round (
        .st   (st),
        .rk   (rk_data),
        .last (last),
        .nxt  (nxt)
    );

    // sequencer FSM: load + initial AddRoundKey, NR rounds, then hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rnd           <= '0;
            st            <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
`ifdef AES_ROUND_SEQ_ABORT_EN
        end else if (abort && state != IDLE) begin
            state         <= IDLE;
            rnd           <= '0;
            st            <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    st           <= bus.in_data ^ rk_data;
                    rnd          <= RKI_W'(1);
                    state        <= RUN;
                    bus.in_ready <= 1'b0;
                    busy         <= 1'b1;
                end
                RUN: begin
                    st <= nxt;
                    if (last) begin
                        rnd           <= '0;
                        state         <= DONE;
                        busy          <= 1'b0;
                        bus.out_valid <= 1'b1;
                    end else begin
                        rnd <= rnd + 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_seq.sv
// tb_aes_round_seq: vector table + random blocks against a byte-level AES model
module tb_aes_round_seq;

    localparam int NR    = 10;
    localparam int RKI_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [RKI_W-1:0] rk_idx;
    logic [127:0]     rk_data;
    logic             busy;
    logic [127:0]     rks [0:NR];
    logic [7:0]       msbox [256];
    int               checks = 0;
    int               errors = 0;

    aes_round_seq_if bus();

`ifdef AES_ROUND_SEQ_ABORT_EN
    logic abort = 1'b0;
`endif

    aes_round_seq #(.NR(NR), .RKI_W(RKI_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .rk_idx  (rk_idx),
        .rk_data (rk_data),
`ifdef AES_ROUND_SEQ_ABORT_EN
        .abort   (abort),
`endif
        .busy    (busy)
    );

    assign rk_data = (int'(rk_idx) <= NR) ? rks[rk_idx] : '0;

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [127:0] pt;
        logic [127:0] ct;
        int           hold;
        bit           chk_rk;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box derived from first principles: multiplicative inverse then the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            msbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {msbox[t[23:16]], msbox[t[15:8]], msbox[t[7:0]], msbox[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k <= NR; k++) rks[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    function automatic logic [127:0] model_enc(input logic [127:0] pt);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] res;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = pt[127-32*c-8*r -: 8] ^ rks[0][127-32*c-8*r -: 8];
        for (int k = 1; k <= NR; k++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = msbox[s[r][(c+r)%4]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] = (k < NR) ? gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c]
                                       : t[r][c];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] ^= rks[k][127-32*c-8*r -: 8];
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                res[127-32*c-8*r -: 8] = s[r][c];
        return res;
    endfunction

    // one block: accept, count latency while toggling ignored inputs, optional back-pressure, release
    task automatic run_vec(input logic [127:0] pt, input logic [127:0] exp, input int hold, input bit chk_rk);
        int lat;
        chk("idle_in_ready", bus.in_ready, 1'b1);
        if (chk_rk) chk("rk_idx_idle", rk_idx, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = pt;
        step();
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            if (chk_rk) begin
                chk($sformatf("rk_idx_r%0d", lat + 1), rk_idx, lat + 1);
                chk("run_busy", busy, 1'b1);
                chk("run_in_ready", bus.in_ready, 1'b0);
            end
            bus.in_valid = 1'($urandom());
            bus.in_data  = rnd128();
            step();
            lat++;
        end
        bus.in_valid = 1'b0;
        chk("latency", lat, NR);
        chk("ciphertext", bus.out_data, exp);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_out_valid", bus.out_valid, 1'b1);
            chk("hold_out_data", bus.out_data, exp);
            chk("hold_in_ready", bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("release_in_ready", bus.in_ready, 1'b1);
        chk("release_out_valid", bus.out_valid, 1'b0);
    endtask

    initial begin
        logic [127:0] q [$];
        logic [127:0] pts [3];
        logic [127:0] pt, e;
        int n, outs, acc, last_t, cyc;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        build_sbox();
        load_key(128'h000102030405060708090a0b0c0d0e0f);
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rk_idx", rk_idx, 0);
        chk("rst_out_data", bus.out_data, 0);

        vt[0].pt = 128'h00112233445566778899aabbccddeeff;
        vt[0].ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        vt[0].hold = 0;
        vt[0].chk_rk = 1'b1;
        for (int i = 1; i < 6; i++) begin
            vt[i].pt = rnd128();
            vt[i].ct = model_enc(vt[i].pt);
            vt[i].hold = (i == 1) ? 20 : int'($urandom_range(0, 3));
            vt[i].chk_rk = 1'b0;
        end
        for (int i = 0; i < 6; i++) run_vec(vt[i].pt, vt[i].ct, vt[i].hold, vt[i].chk_rk);

        pt = rnd128();
        bus.in_valid = 1'b1;
        bus.in_data  = pt;
        step();
        bus.in_valid = 1'b0;
        n = 0;
        while (rk_idx != 5 && n < 20) begin
            step();
            n++;
        end
        chk("reach_rnd5", rk_idx, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_in_ready", bus.in_ready, 1'b1);
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        pt = rnd128();
        run_vec(pt, model_enc(pt), 0, 1'b0);

        for (int i = 0; i < 3; i++) pts[i] = rnd128();
        outs = 0;
        acc = 0;
        last_t = -1;
        cyc = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = pts[0];
        while (outs < 3 && cyc < 100) begin
            if (bus.out_valid) begin
                e = (q.size() > 0) ? q.pop_front() : 'x;
                chk("b2b_data", bus.out_data, e);
                if (last_t >= 0) chk("b2b_gap", cyc - last_t, NR + 2);
                last_t = cyc;
                outs++;
            end
            if (bus.in_ready && bus.in_valid) begin
                q.push_back(model_enc(bus.in_data));
                acc++;
            end
            step();
            cyc++;
            if (acc >= 3) bus.in_valid = 1'b0;
            else bus.in_data = pts[acc];
        end
        bus.in_valid  = 1'b0;
        chk("b2b_count", outs, 3);
        chk("b2b_left", q.size(), 0);
        step();
        bus.out_ready = 1'b0;

        for (int k = 0; k <= NR; k++) rks[k] = rnd128();
        for (int i = 0; i < 4; i++) begin
            pt = rnd128();
            run_vec(pt, model_enc(pt), int'($urandom_range(0, 2)), 1'b0);
        end

`ifdef AES_ROUND_SEQ_ABORT_EN
        bus.in_valid = 1'b1;
        bus.in_data  = rnd128();
        step();
        bus.in_valid = 1'b0;
        n = 0;
        while (rk_idx != 3 && n < 20) begin
            step();
            n++;
        end
        chk("reach_rnd3", rk_idx, 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_in_ready", bus.in_ready, 1'b1);
        chk("abort_out_valid", bus.out_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_rk_idx", rk_idx, 0);
        chk("abort_out_data", bus.out_data, 0);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.out_valid) n++;
        end
        chk("abort_no_output", n, 0);
        pt = rnd128();
        bus.in_valid = 1'b1;
        bus.in_data  = pt;
        step();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            step();
            n++;
        end
        chk("abort_done_ct", bus.out_data, model_enc(pt));
        abort = 1'b1;
        bus.out_ready = 1'b1;
        step();
        abort = 1'b0;
        bus.out_ready = 1'b0;
        chk("abort_wins_data", bus.out_data, 0);
        chk("abort_wins_valid", bus.out_valid, 1'b0);
        chk("abort_wins_ready", bus.in_ready, 1'b1);
        pt = rnd128();
        abort = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = pt;
        step();
        abort = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_idle_accept", busy, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            step();
            n++;
        end
        chk("abort_idle_ct", bus.out_data, model_enc(pt));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_round_seq.md
Name: aes_round_seq

Overview:
- Iterative AES encryption round sequencer: accepts one 128-bit plaintext block and computes one full round per clock.
- Each round applies SubBytes, ShiftRows, MixColumns and AddRoundKey to a single state register, reusing one combinational mixcolumn instance.
- Round keys come from an external key store through an index/data port, so key expansion stays outside this block.
- Sits between the host-side block interface (valid/ready) and the key-schedule storage.

Parameters:
- NR, 10, number of rounds; legal values 10, 12 and 14 (AES-128/192/256 key stores); any other value is a compile-time error.
- RKI_W, 4, width of the round-key index.

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, plaintext offered.
- in_ready, output, 1, block can accept plaintext.
- in_data, input, 128, plaintext; column 0 in [127:96], byte s(r,c) at [127-32c-8r -: 8].
- rk_idx, output, RKI_W, round-key index requested this cycle.
- rk_data, input, 128, round key for rk_idx; combinational, valid the same cycle, same byte layout.
- out_valid, output, 1, ciphertext available.
- out_ready, input, 1, consumer accepts ciphertext.
- out_data, output, 128, ciphertext, same byte layout.
- busy, output, 1, high in RUN.

Behaviour:
- FSM states: IDLE, RUN, DONE. A round counter rnd (RKI_W bits) and a 128-bit state register st.
- Reset: FSM=IDLE, rnd=0, st=0. Outputs after reset: in_ready=1, out_valid=0, busy=0, rk_idx=0, out_data=0.
- IDLE:
  - in_ready=1, rk_idx=0.
  - On in_valid: st <= in_data ^ rk_data (initial AddRoundKey), rnd <= 1, go to RUN.
- RUN:
  - in_ready=0, rk_idx=rnd.
  - Each cycle: st <= MixColumns(ShiftRows(SubBytes(st))) ^ rk_data, except when rnd==NR, where MixColumns is skipped.
  - If rnd<NR: rnd <= rnd+1. If rnd==NR: go to DONE, rnd <= 0.
- DONE:
  - out_valid=1, out_data=st; out_data and out_valid hold stable until out_ready.
  - On out_ready: go to IDLE. The next plaintext is accepted no earlier than the following cycle; there is no same-cycle turnaround.
- Latency: accept at edge T, out_valid high after edge T+NR (10 cycles for NR=10). Throughput: one block per NR+2 cycles with out_ready held high.
- ShiftRows: row r rotated left by r columns. SubBytes: FIPS-197 S-box per byte. MixColumns: standard GF(2^8) matrix [2 3 1 1] using polynomial 0x11B.
- in_data and in_valid are ignored outside IDLE. out_ready is ignored outside DONE.
- Reset in any state discards the block in flight; no output is produced for it.
- rk_idx never exceeds NR.

Optional Feature:
- Macro AES_ROUND_SEQ_ABORT_EN.
- Defined: adds input port abort (1 bit). abort=1 in RUN or DONE returns to IDLE the next cycle, with rnd=0 and out_valid=0; st is cleared to 0. abort has priority over completion and over out_ready in the same cycle. abort is ignored in IDLE; in_valid is still honoured there.
- Not defined: no abort port; a block runs to completion once accepted.

Decomposition:
- Package aes_pkg holds:
  - the 256-entry S-box constant and an sbox function;
  - the xtime and mul_3 functions;
  - FSM state typedef seq_state_t {IDLE, RUN, DONE};
  - constants AES_BLK_W=128 and the legal NR values.
- Sub-module aes_round_fn: purely combinational; inputs st, rk, last; output next state. It instantiates the existing mixcolumn module and bypasses it when last=1.
- aes_round_seq holds only the FSM, counter, state register and handshake logic.

Test Plan:
- FIPS-197 C.1: NR=10, key store from key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff → out_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 10 cycles after accept; rk_idx sequence 0,1..10.
- Back-pressure: hold out_ready=0 for 20 cycles → out_valid and out_data stable, in_ready=0 throughout; release → IDLE next cycle.
- Back-to-back: three blocks with in_valid and out_ready tied high → one result per 12 cycles, each matching the reference model, no drops or duplicates.
- Reset mid-RUN at rnd=5 → next cycle in_ready=1, out_valid=0, busy=0; a following block encrypts correctly.
- Ignored input: toggle in_valid with garbage in_data during RUN → result unaffected.
- With AES_ROUND_SEQ_ABORT_EN: abort at rnd=3 → IDLE next cycle, no out_valid. Abort asserted together with out_ready in DONE → abort wins, st=0.
